mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/swt16_pkg.sv | 19 +
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_lsu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
// Shared encodings for the load/store unit: memory op codes and LSU FSM states.
package swt16_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LB   = 3'd1,
    OP_LBU  = 3'd2,
    OP_LW   = 3'd3,
    OP_SB   = 3'd4,
    OP_SW   = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte out of a little-endian read word and extends it for LB/LBU.
module mem_load_align
  import swt16_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LANE_W = 1
) (
  input  logic [LANE_W-1:0] i_lane,
  input  logic [2:0]        i_op,
  input  logic [WORD_W-1:0] i_rdata,
  output logic [WORD_W-1:0] o_res
);

  logic [7:0] w_byte;

  assign w_byte = i_rdata[i_lane*8 +: 8];

  always_comb begin
    o_res = i_rdata;
    if (i_op == OP_LB)
      o_res = {{(WORD_W-8){w_byte[7]}}, w_byte};
    else if (i_op == OP_LBU)
      o_res = {{(WORD_W-8){1'b0}}, w_byte};
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between EX and WB: one outstanding DMEM access, stalls upstream while busy.
module mem_lsu
  import swt16_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int PC_WIDTH        = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [2:0]                   in_op,
  input  logic [DMEM_ADDR_WIDTH-1:0]   in_addr,
  input  logic [DMEM_WORD_WIDTH-1:0]   in_wr_data,
  input  logic [DMEM_WORD_WIDTH-1:0]   in_res,
  input  logic [REG_IDX_WIDTH-1:0]     in_res_reg_idx,
  input  logic                         in_write_res,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_stall,
  output logic                         dmem_req,
  output logic                         dmem_we,
  output logic [DMEM_WORD_WIDTH/8-1:0] dmem_be,
  output logic [DMEM_ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0]   dmem_wdata,
  input  logic                         dmem_gnt,
  input  logic                         dmem_rvalid,
  input  logic [DMEM_WORD_WIDTH-1:0]   dmem_rdata,
  output logic                         out_valid,
  output logic [DMEM_WORD_WIDTH-1:0]   out_res,
  output logic [REG_IDX_WIDTH-1:0]     out_res_reg_idx,
  output logic                         out_write_res,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         out_misalign
);

  localparam int BYTES  = DMEM_WORD_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);

  lsu_state_e r_state, w_state_nxt;

  logic                       r_dmem_req, r_dmem_we;
  logic [BYTES-1:0]           r_dmem_be;
  logic [DMEM_ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DMEM_WORD_WIDTH-1:0] r_dmem_wdata;
  logic [2:0]                 r_op;
  logic [LANE_W-1:0]          r_lane;
  logic [REG_IDX_WIDTH-1:0]   r_idx;
  logic                       r_write;
  logic [PC_WIDTH-1:0]        r_pc;
  logic                       r_out_valid, r_out_write, r_out_misalign;
  logic [DMEM_WORD_WIDTH-1:0] r_out_res;
  logic [REG_IDX_WIDTH-1:0]   r_out_idx;
  logic [PC_WIDTH-1:0]        r_out_pc;

  logic [LANE_W-1:0]          w_lane;
  logic                       w_is_load, w_is_store, w_is_sb, w_misalign;
  logic                       w_accept, w_mem_go;
  logic [BYTES-1:0]           w_be_onehot;
  logic [DMEM_WORD_WIDTH-1:0] w_load_res;

  assign w_lane      = in_addr[LANE_W-1:0];
  assign w_is_load   = (in_op == OP_LB) || (in_op == OP_LBU) || (in_op == OP_LW);
  assign w_is_sb     = (in_op == OP_SB);
  assign w_is_store  = w_is_sb || (in_op == OP_SW);
  // Word accesses must be lane-aligned; byte accesses may hit any lane.
  assign w_misalign  = ((in_op == OP_LW) || (in_op == OP_SW)) && (w_lane != '0);
  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_mem_go    = w_accept && (w_is_load || w_is_store) && !w_misalign;
  assign w_be_onehot = {{(BYTES-1){1'b0}}, 1'b1} << w_lane;

  mem_load_align #(.WORD_W(DMEM_WORD_WIDTH), .LANE_W(LANE_W)) u_align (
    .i_lane (r_lane),
    .i_op   (r_op),
    .i_rdata(dmem_rdata),
    .o_res  (w_load_res)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A gnt that coincides with rvalid only advances REQ->RSP; rvalid is consumed later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_go)    w_state_nxt = ST_REQ;
      ST_REQ:  if (dmem_gnt)    w_state_nxt = r_dmem_we ? ST_IDLE : ST_RSP;
      ST_RSP:  if (dmem_rvalid) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_be      <= '0;
      r_dmem_addr    <= '0;
      r_dmem_wdata   <= '0;
      r_op           <= '0;
      r_lane         <= '0;
      r_idx          <= '0;
      r_write        <= 1'b0;
      r_pc           <= '0;
      r_out_valid    <= 1'b0;
      r_out_write    <= 1'b0;
      r_out_misalign <= 1'b0;
      r_out_res      <= '0;
      r_out_idx      <= '0;
      r_out_pc       <= '0;
    end else begin
      r_out_valid    <= 1'b0;
      r_out_write    <= 1'b0;
      r_out_misalign <= 1'b0;
      if (w_mem_go) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= w_is_store;
        r_dmem_addr  <= {in_addr[DMEM_ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
        r_dmem_be    <= w_is_sb ? w_be_onehot : '1;
        r_dmem_wdata <= w_is_sb ? {BYTES{in_wr_data[7:0]}} :
                        (w_is_store ? in_wr_data : '0);
        r_op         <= in_op;
        r_lane       <= w_lane;
        r_idx        <= in_res_reg_idx;
        r_write      <= in_write_res;
        r_pc         <= in_pc;
      end else if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_out_res      <= w_misalign ? '0 : in_res;
        r_out_idx      <= in_res_reg_idx;
        r_out_pc       <= in_pc;
        r_out_write    <= in_write_res && !w_misalign;
        r_out_misalign <= w_misalign;
      end
      if ((r_state == ST_REQ) && dmem_gnt) begin
        r_dmem_req <= 1'b0;
        if (r_dmem_we) begin
          r_out_valid <= 1'b1;
          r_out_res   <= '0;
          r_out_idx   <= r_idx;
          r_out_pc    <= r_pc;
        end
      end
      if ((r_state == ST_RSP) && dmem_rvalid) begin
        r_out_valid <= 1'b1;
        r_out_res   <= w_load_res;
        r_out_idx   <= r_idx;
        r_out_pc    <= r_pc;
        r_out_write <= r_write;
      end
    end
  end

  assign out_stall       = (r_state != ST_IDLE);
  assign dmem_req        = r_dmem_req;
  assign dmem_we         = r_dmem_we;
  assign dmem_be         = r_dmem_be;
  assign dmem_addr       = r_dmem_addr;
  assign dmem_wdata      = r_dmem_wdata;
  assign out_valid       = r_out_valid;
  assign out_res         = r_out_res;
  assign out_res_reg_idx = r_out_idx;
  assign out_write_res   = r_out_write;
  assign out_pc          = r_out_pc;
  assign out_misalign    = r_out_misalign;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, stores, loads, misalignment, reset abort, back-to-back.
module tb_mem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [11:0] in_addr;
  logic [15:0] in_wr_data, in_res;
  logic [3:0]  in_res_reg_idx;
  logic        in_write_res;
  logic [11:0] in_pc;
  logic        out_stall, dmem_req, dmem_we;
  logic [1:0]  dmem_be;
  logic [11:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [15:0] dmem_rdata;
  logic        out_valid;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;
  logic        out_write_res;
  logic [11:0] out_pc;
  logic        out_misalign;

  int checks = 0;
  int passed = 0;

  mem_lsu dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_wr_data(in_wr_data), .in_res(in_res), .in_res_reg_idx(in_res_reg_idx),
    .in_write_res(in_write_res), .in_pc(in_pc), .out_stall(out_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_res(out_res), .out_res_reg_idx(out_res_reg_idx),
    .out_write_res(out_write_res), .out_pc(out_pc), .out_misalign(out_misalign)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_addr = 0; in_wr_data = 0; in_res = 0;
    in_res_reg_idx = 0; in_write_res = 0; in_pc = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic present(input logic [2:0] op, input logic [11:0] addr, input logic [15:0] wd,
                         input logic [15:0] res, input logic [3:0] idx, input logic wr,
                         input logic [11:0] pc);
    in_valid = 1; in_op = op; in_addr = addr; in_wr_data = wd; in_res = res;
    in_res_reg_idx = idx; in_write_res = wr; in_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    present(3'd5, 12'h004, 16'hFFFF, 16'hFFFF, 4'hF, 1'b1, 12'hFFF);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", out_valid); else passed++;
    checks++; if (out_stall !== 1'b0) $display("FAIL rst_stall: got %b exp 0", out_stall); else passed++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", dmem_req); else passed++;
    checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 31'd0)
      $display("FAIL rst_dmem: got we=%b be=%b addr=%h wdata=%h exp all 0", dmem_we, dmem_be, dmem_addr, dmem_wdata); else passed++;
    checks++; if ({out_res, out_res_reg_idx, out_write_res, out_pc, out_misalign} !== 34'd0)
      $display("FAIL rst_out: got res=%h idx=%h wr=%b pc=%h mis=%b exp all 0", out_res, out_res_reg_idx, out_write_res, out_pc, out_misalign); else passed++;
    idle_inputs();
    reset = 1;
    tick();
  endtask

  task automatic test_none();
    int stall_seen = 0;
    present(3'd0, 12'h000, 16'h0000, 16'h1234, 4'd3, 1'b1, 12'h010);
    if (out_stall) stall_seen++;
    tick();
    in_valid = 0;
    if (out_stall) stall_seen++;
    checks++; if (out_valid !== 1'b1) $display("FAIL none_valid: got %b exp 1", out_valid); else passed++;
    checks++; if (out_res !== 16'h1234) $display("FAIL none_res: got %h exp 1234", out_res); else passed++;
    checks++; if (out_res_reg_idx !== 4'd3) $display("FAIL none_idx: got %0d exp 3", out_res_reg_idx); else passed++;
    checks++; if (out_write_res !== 1'b1 || out_pc !== 12'h010)
      $display("FAIL none_wr_pc: got wr=%b pc=%h exp wr=1 pc=010", out_write_res, out_pc); else passed++;
    tick();
    if (out_stall) stall_seen++;
    checks++; if (out_valid !== 1'b0 || out_write_res !== 1'b0)
      $display("FAIL none_pulse: got valid=%b wr=%b exp 0 0", out_valid, out_write_res); else passed++;
    checks++; if (stall_seen !== 0) $display("FAIL none_stall: got %0d stall cycles exp 0", stall_seen); else passed++;
    // reserved op behaves as pass-through
    present(3'd6, 12'h003, 16'h0000, 16'hBEEF, 4'd9, 1'b1, 12'h014);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_res !== 16'hBEEF || out_res_reg_idx !== 4'd9 || dmem_req !== 1'b0)
      $display("FAIL rsvd_op: got valid=%b res=%h idx=%0d req=%b exp 1 beef 9 0", out_valid, out_res, out_res_reg_idx, dmem_req); else passed++;
    tick();
  endtask

  task automatic test_sb();
    int stall_cyc = 0;
    present(3'd4, 12'h005, 16'h00AB, 16'h0000, 4'd7, 1'b1, 12'h020);
    tick();
    in_valid = 0;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1)
      $display("FAIL sb_req: got req=%b we=%b exp 1 1", dmem_req, dmem_we); else passed++;
    checks++; if (dmem_addr !== 12'h004) $display("FAIL sb_addr: got %h exp 004", dmem_addr); else passed++;
    checks++; if (dmem_be !== 2'b10) $display("FAIL sb_be: got %b exp 10", dmem_be); else passed++;
    checks++; if (dmem_wdata !== 16'hABAB) $display("FAIL sb_wdata: got %h exp abab", dmem_wdata); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (out_stall) stall_cyc++;
      checks++; if (dmem_req !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL sb_hold%0d: got req=%b valid=%b exp 1 0", i, dmem_req, out_valid); else passed++;
      if (i == 2) dmem_gnt = 1;
      tick();
    end
    dmem_gnt = 0;
    checks++; if (stall_cyc !== 3 || out_stall !== 1'b0)
      $display("FAIL sb_stall: got %0d cycles, stall now %b exp 3, 0", stall_cyc, out_stall); else passed++;
    checks++; if (out_valid !== 1'b1 || out_write_res !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL sb_done: got valid=%b wr=%b req=%b exp 1 0 0", out_valid, out_write_res, dmem_req); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL sb_pulse: got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_sw();
    present(3'd5, 12'h006, 16'h1357, 16'h0000, 4'd2, 1'b1, 12'h030);
    tick();
    in_valid = 0;
    checks++; if (dmem_be !== 2'b11 || dmem_wdata !== 16'h1357 || dmem_addr !== 12'h006)
      $display("FAIL sw_req: got be=%b wdata=%h addr=%h exp 11 1357 006", dmem_be, dmem_wdata, dmem_addr); else passed++;
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    checks++; if (out_valid !== 1'b1 || out_write_res !== 1'b0 || out_pc !== 12'h030)
      $display("FAIL sw_done: got valid=%b wr=%b pc=%h exp 1 0 030", out_valid, out_write_res, out_pc); else passed++;
    tick();
  endtask

  task automatic test_load(input string nm, input logic [2:0] op, input logic [15:0] exp_res);
    present(op, 12'h003, 16'h0000, 16'h0000, 4'd5, 1'b1, 12'h040);
    tick();
    in_valid = 0;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 12'h002)
      $display("FAIL %s_req: got req=%b we=%b addr=%h exp 1 0 002", nm, dmem_req, dmem_we, dmem_addr); else passed++;
    // gnt with a stray rvalid in the same cycle acts as gnt only
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 16'hDEAD;
    tick();
    dmem_gnt = 0; dmem_rvalid = 0;
    checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0 || out_stall !== 1'b1)
      $display("FAIL %s_rsp: got valid=%b req=%b stall=%b exp 0 0 1", nm, out_valid, dmem_req, out_stall); else passed++;
    tick(); tick();
    dmem_rvalid = 1; dmem_rdata = 16'h80FF;
    tick();
    dmem_rvalid = 0; dmem_rdata = 16'h0000;
    checks++; if (out_valid !== 1'b1 || out_res !== exp_res)
      $display("FAIL %s_res: got valid=%b res=%h exp 1 %h", nm, out_valid, out_res, exp_res); else passed++;
    checks++; if (out_write_res !== 1'b1 || out_res_reg_idx !== 4'd5 || out_stall !== 1'b0)
      $display("FAIL %s_wb: got wr=%b idx=%0d stall=%b exp 1 5 0", nm, out_write_res, out_res_reg_idx, out_stall); else passed++;
    tick();
  endtask

  task automatic test_misalign();
    present(3'd3, 12'h007, 16'h0000, 16'h4444, 4'd6, 1'b1, 12'h050);
    tick();
    in_valid = 0;
    checks++; if (dmem_req !== 1'b0 || out_stall !== 1'b0)
      $display("FAIL mis_req: got req=%b stall=%b exp 0 0", dmem_req, out_stall); else passed++;
    checks++; if (out_misalign !== 1'b1 || out_valid !== 1'b1 || out_write_res !== 1'b0)
      $display("FAIL mis_flag: got mis=%b valid=%b wr=%b exp 1 1 0", out_misalign, out_valid, out_write_res); else passed++;
    tick();
    checks++; if (out_misalign !== 1'b0 || out_valid !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL mis_pulse: got mis=%b valid=%b req=%b exp 0 0 0", out_misalign, out_valid, dmem_req); else passed++;
  endtask

  task automatic test_reset_mid();
    present(3'd3, 12'h004, 16'h0000, 16'h0000, 4'd8, 1'b1, 12'h060);
    tick();
    in_valid = 0;
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    reset = 0;
    tick();
    reset = 1;
    checks++; if (out_stall !== 1'b0 || dmem_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rmid_abort: got stall=%b req=%b valid=%b exp 0 0 0", out_stall, dmem_req, out_valid); else passed++;
    dmem_rvalid = 1; dmem_rdata = 16'h7777;
    tick();
    dmem_rvalid = 0;
    checks++; if (out_valid !== 1'b0 || out_stall !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL rmid_late: got valid=%b stall=%b req=%b exp 0 0 0", out_valid, out_stall, dmem_req); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    present(3'd3, 12'h008, 16'h0000, 16'h0000, 4'd1, 1'b1, 12'h070);
    tick();
    present(3'd0, 12'h000, 16'h0000, 16'h5555, 4'd2, 1'b1, 12'h074);
    checks++; if (out_stall !== 1'b1) $display("FAIL b2b_hold: got stall=%b exp 1", out_stall); else passed++;
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    checks++; if (out_stall !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_wait: got stall=%b valid=%b exp 1 0", out_stall, out_valid); else passed++;
    dmem_rvalid = 1; dmem_rdata = 16'hA5A5;
    tick();
    dmem_rvalid = 0;
    checks++; if (out_valid !== 1'b1 || out_res !== 16'hA5A5 || out_pc !== 12'h070 || out_res_reg_idx !== 4'd1)
      $display("FAIL b2b_first: got valid=%b res=%h pc=%h idx=%0d exp 1 a5a5 070 1", out_valid, out_res, out_pc, out_res_reg_idx); else passed++;
    checks++; if (out_stall !== 1'b0) $display("FAIL b2b_release: got stall=%b exp 0", out_stall); else passed++;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_res !== 16'h5555 || out_pc !== 12'h074 || out_res_reg_idx !== 4'd2)
      $display("FAIL b2b_second: got valid=%b res=%h pc=%h idx=%0d exp 1 5555 074 2", out_valid, out_res, out_pc, out_res_reg_idx); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end: got valid=%b exp 0", out_valid); else passed++;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_none();
    test_sb();
    test_sw();
    test_load("lb", 3'd1, 16'hFF80);
    test_load("lbu", 3'd2, 16'h0080);
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
